// File: rtl/regfile_checker.sv
// regfile_checker: shadows register-file writebacks and scans them against an expected table on halt/timeout.
// Define CHECKER_ERRSCAN_EN to scan every entry and count all mismatches instead of stopping at the first.
module regfile_checker #(
  parameter int DATA_W      = 32,
  parameter int NREGS       = 15,
  parameter int IDX_W       = 4,
  parameter int CYC_W       = 16,
  parameter int CYCLE_LIMIT = 2500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [NREGS-1:0]  exp_mask,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_got,
  output logic [DATA_W-1:0] fail_exp,
  output logic [IDX_W:0]    err_count,
  output logic [CYC_W-1:0]  cycles
);
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
`ifdef CHECKER_ERRSCAN_EN
  localparam bit STOP_FIRST = 1'b0;
`else
  localparam bit STOP_FIRST = 1'b1;
`endif
  localparam logic [IDX_W:0] NR = (IDX_W+1)'(NREGS);
  state_t state, state_nx;
  logic [DATA_W-1:0] shadow [NREGS];
  logic [DATA_W-1:0] tbl [NREGS];
  logic [IDX_W-1:0] idx;
  logic start_ok, run_end, mismatch, last;
  always_comb begin
    start_ok = start && (state == IDLE || state == DONE);
    run_end  = halt || cycles == CYC_W'(CYCLE_LIMIT - 1);
    mismatch = exp_mask[idx] && shadow[idx] != tbl[idx];
    last     = idx == IDX_W'(NREGS - 1);
    state_nx = start_ok ? RUN :
               (state == RUN && run_end) ? CHECK :
               (state == CHECK && (last || (STOP_FIRST && mismatch))) ? DONE : state;
    busy = state == RUN || state == CHECK;
    done = state == DONE;
    pass = done && err_count == '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow[i] <= '0;
        tbl[i]    <= '0;
      end
      idx       <= '0;
      cycles    <= '0;
      err_count <= '0;
      fail_idx  <= '0;
      fail_got  <= '0;
      fail_exp  <= '0;
    end else begin
      if (state == IDLE && exp_we && {1'b0, exp_addr} < NR) tbl[exp_addr] <= exp_data;
      if (start_ok) begin
        for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
        idx       <= '0;
        cycles    <= '0;
        err_count <= '0;
        fail_idx  <= '0;
        fail_got  <= '0;
        fail_exp  <= '0;
      end
      if (state == RUN) begin
        if (wb_en && {1'b0, wb_addr} < NR) shadow[wb_addr] <= wb_data;
        if (!run_end) cycles <= cycles + 1'b1;
      end
      if (state == CHECK) begin
        idx <= idx + 1'b1;
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
          if (err_count == '0) begin
            fail_idx <= idx;
            fail_got <= shadow[idx];
            fail_exp <= tbl[idx];
          end
        end
      end
    end
endmodule
